// File: rtl/cnn_pkg.sv
// Shared CNN-pipeline definitions: default pixel width, map sizes and the
// row-phase encoding used by the upsampling stage.
package cnn_pkg;

  localparam int unsigned PIX_W   = 32;  // default pixel width
  localparam int unsigned MAP_OUT = 26;  // upsampled map width/height
  localparam int unsigned MAP_IN  = 13;  // pooled map width/height

  // S_ROW_A emits even output rows (live input), S_ROW_B odd rows (replay)
  typedef enum logic {
    S_ROW_A = 1'b0,
    S_ROW_B = 1'b1
  } row_state_t;

endpackage

// File: rtl/unpool_linebuf.sv
// One-row line buffer for the unpool stage: W entries of In_d_W bits,
// one synchronous write port and one combinational read port, both indexed
// by column. Contents are not reset.
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write column
//   wr_data  - write pixel
//   rd_addr  - read column
//   rd_data  - pixel stored at rd_addr
module unpool_linebuf
  import cnn_pkg::*;
#(
  parameter int unsigned In_d_W = PIX_W,
  parameter int unsigned W      = MAP_IN,
  parameter int unsigned CW     = $clog2(W) + 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_addr,
  input  logic [In_d_W-1:0] wr_data,
  input  logic [CW-1:0]     rd_addr,
  output logic [In_d_W-1:0] rd_data
);

  localparam int unsigned AW = (W > 1) ? $clog2(W) : 1;

  logic [In_d_W-1:0] mem [W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_addr[AW-1:0]];

endmodule

// File: rtl/unpool_upsample.sv
// Streaming 2x upsampler: a W x W raster of signed pixels in, a 2W x 2W
// raster out, each input pixel expanded into a 2x2 block. Even output rows
// are produced while input streams in; odd rows are replayed from a line
// buffer with input stalled.
// Build option: UNPOOL_ZERO_FILL_EN selects bed-of-nails unpooling (only
// the top-left of each 2x2 block carries the pixel, others are 0, no line
// buffer). Default is nearest-neighbour replication.
//   iClk      - clock
//   iRsn      - asynchronous active-low reset
//   iInValid  - input pixel valid
//   oInReady  - input accepted this cycle
//   iInData   - signed input pixel
//   oOutValid - output pixel valid (registered)
//   iOutReady - downstream accepts output
//   oOutData  - signed output pixel (registered)
//   oOutLast  - final beat of a 2W x 2W frame (registered)
module unpool_upsample
  import cnn_pkg::*;
#(
  parameter int unsigned In_d_W = PIX_W,
  parameter int unsigned W      = MAP_IN
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iInValid,
  output logic              oInReady,
  input  logic [In_d_W-1:0] iInData,
  output logic              oOutValid,
  input  logic              iOutReady,
  output logic [In_d_W-1:0] oOutData,
  output logic              oOutLast
);

  localparam int unsigned    CW       = $clog2(W) + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(W - 1);

  row_state_t        state;
  logic [CW-1:0]     col;
  logic [CW-1:0]     row;
  logic              dup_phase;

  logic              out_free;
  logic              in_beat;
  logic              col_end;
  logic              row_end;
  logic [In_d_W-1:0] a_copy;   // second horizontal copy in an even row
  logic [In_d_W-1:0] b_data;   // value presented in an odd row

  assign out_free = !oOutValid || iOutReady;
  assign oInReady = (state == S_ROW_A) && !dup_phase && out_free;
  assign in_beat  = iInValid && oInReady;
  assign col_end  = (col == LAST_IDX);
  assign row_end  = (row == LAST_IDX);

`ifdef UNPOOL_ZERO_FILL_EN
  assign a_copy = '0;
  assign b_data = '0;
`else
  logic [In_d_W-1:0] rd_data;

  unpool_linebuf #(
    .In_d_W (In_d_W),
    .W      (W),
    .CW     (CW)
  ) u_linebuf (
    .clk     (iClk),
    .wr_en   (in_beat),
    .wr_addr (col),
    .wr_data (iInData),
    .rd_addr (col),
    .rd_data (rd_data)
  );

  // the output register still holds the pixel just accepted
  assign a_copy = oOutData;
  assign b_data = rd_data;
`endif

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state     <= S_ROW_A;
      col       <= '0;
      row       <= '0;
      dup_phase <= 1'b0;
      oOutValid <= 1'b0;
      oOutData  <= '0;
      oOutLast  <= 1'b0;
    end else begin
      case (state)
        S_ROW_A: begin
          if (in_beat) begin
            oOutData  <= iInData;
            oOutValid <= 1'b1;
            oOutLast  <= 1'b0;
            dup_phase <= 1'b1;
          end else if (dup_phase && out_free) begin
            oOutData  <= a_copy;
            oOutValid <= 1'b1;
            oOutLast  <= 1'b0;
            dup_phase <= 1'b0;
            if (col_end) begin
              col   <= '0;
              state <= S_ROW_B;
            end else begin
              col <= col + CW'(1);
            end
          end else if (out_free) begin
            oOutValid <= 1'b0;
            oOutLast  <= 1'b0;
          end
        end
        S_ROW_B: begin
          if (out_free) begin
            oOutData  <= b_data;
            oOutValid <= 1'b1;
            oOutLast  <= dup_phase && col_end && row_end;
            dup_phase <= !dup_phase;
            if (dup_phase) begin
              if (col_end) begin
                col   <= '0;
                state <= S_ROW_A;
                row   <= row_end ? '0 : row + CW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        default: state <= S_ROW_A;
      endcase
    end
  end

endmodule

// File: tb/tb_unpool_upsample.sv
// Directed bench for unpool_upsample: a W=2 instance for the small
// pattern/stall/reset scenarios and a W=13 instance for full-size frames.
module tb_unpool_upsample;

  typedef logic signed [31:0] px_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // W=2 instance
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  px_t  a_in_data, a_out_data;
  // W=13 instance
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  px_t  b_in_data, b_out_data;

  unpool_upsample #(.In_d_W(32), .W(2)) dut2 (
    .iClk(clk), .iRsn(rst_n),
    .iInValid(a_in_valid), .oInReady(a_in_ready), .iInData(a_in_data),
    .oOutValid(a_out_valid), .iOutReady(a_out_ready), .oOutData(a_out_data),
    .oOutLast(a_out_last)
  );

  unpool_upsample #(.In_d_W(32), .W(13)) dut13 (
    .iClk(clk), .iRsn(rst_n),
    .iInValid(b_in_valid), .oInReady(b_in_ready), .iInData(b_in_data),
    .oOutValid(b_out_valid), .iOutReady(b_out_ready), .oOutData(b_out_data),
    .oOutLast(b_out_last)
  );

  int checks = 0;
  int errors = 0;

  // W=2 stream capture
  px_t         in_vec [4];
  px_t         cap_data [16];
  logic [15:0] cap_last;
  int          nout;
  int          b_ready_viol;
  int          blk_viol;
  int          stab_viol;

  localparam logic [15:0] STALL_PAT = 16'b1001_0110_1100_1011;

  // Drive in_vec into the W=2 instance and capture up to max_out beats.
  task automatic stream2(input int max_out, input bit use_pat);
    int   idx;
    bit   prev_stall;
    px_t  prev_data;
    idx = 0; nout = 0; cap_last = '0;
    b_ready_viol = 0; blk_viol = 0; stab_viol = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int k = 0; k < 300 && nout < max_out; k++) begin
      @(negedge clk);
      a_out_ready = use_pat ? STALL_PAT[k % 16] : 1'b1;
      a_in_valid  = (idx < 4);
      a_in_data   = (idx < 4) ? in_vec[idx] : '0;
      #1;
      if (a_in_ready && a_out_valid && ((nout % 8) inside {4, 5, 6})) b_ready_viol++;
      if (a_out_valid && !a_out_ready && a_in_ready) blk_viol++;
      if (prev_stall && (!a_out_valid || a_out_data !== prev_data)) stab_viol++;
      if (a_out_valid && a_out_ready) begin
        cap_data[nout] = a_out_data;
        cap_last[nout] = a_out_last;
        nout++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_data  = a_out_data;
      if (a_in_valid && a_in_ready) idx++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
    checks++;
    if (a_out_data !== 32'sd0) begin errors++; $display("FAIL reset_data: got %0d want 0", a_out_data); end
    checks++;
    if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", a_out_last); end
    checks++;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    checks++;
    if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid13: got %b want 0", b_out_valid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
`ifdef UNPOOL_ZERO_FILL_EN
    px_t exp_v [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
`else
    px_t exp_v [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
`endif
    in_vec = '{1, 2, 3, 4};
    stream2(16, 1'b0);
    checks++;
    if (nout !== 16) begin errors++; $display("FAIL basic_count: got %0d want 16", nout); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_data[i] !== exp_v[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, cap_data[i], exp_v[i]); end
    end
    checks++;
    if (cap_last !== 16'h8000) begin errors++; $display("FAIL basic_last: got %h want 8000", cap_last); end
    checks++;
    if (b_ready_viol !== 0) begin errors++; $display("FAIL basic_ready_in_row_b: got %0d want 0", b_ready_viol); end
  endtask

  task automatic test_signed();
`ifdef UNPOOL_ZERO_FILL_EN
    px_t exp_v [16] = '{-5,0,7,0, 0,0,0,0, -1,0,0,0, 0,0,0,0};
`else
    px_t exp_v [16] = '{-5,-5,7,7, -5,-5,7,7, -1,-1,0,0, -1,-1,0,0};
`endif
    in_vec = '{-5, 7, -1, 0};
    stream2(16, 1'b0);
    checks++;
    if (nout !== 16) begin errors++; $display("FAIL signed_count: got %0d want 16", nout); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_data[i] !== exp_v[i]) begin errors++; $display("FAIL signed_data[%0d]: got %0d want %0d", i, cap_data[i], exp_v[i]); end
    end
    checks++;
    if (cap_last !== 16'h8000) begin errors++; $display("FAIL signed_last: got %h want 8000", cap_last); end
  endtask

  task automatic test_stall();
`ifdef UNPOOL_ZERO_FILL_EN
    px_t exp_v [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
`else
    px_t exp_v [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
`endif
    in_vec = '{1, 2, 3, 4};
    stream2(16, 1'b1);
    checks++;
    if (nout !== 16) begin errors++; $display("FAIL stall_count: got %0d want 16", nout); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_data[i] !== exp_v[i]) begin errors++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, cap_data[i], exp_v[i]); end
    end
    checks++;
    if (cap_last !== 16'h8000) begin errors++; $display("FAIL stall_last: got %h want 8000", cap_last); end
    checks++;
    if (stab_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stab_viol); end
    checks++;
    if (blk_viol !== 0) begin errors++; $display("FAIL stall_in_blocked: got %0d accepting cycles want 0", blk_viol); end
  endtask

  task automatic test_reset_mid();
`ifdef UNPOOL_ZERO_FILL_EN
    px_t exp_v [16] = '{5,0,6,0, 0,0,0,0, 7,0,8,0, 0,0,0,0};
`else
    px_t exp_v [16] = '{5,5,6,6, 5,5,6,6, 7,7,8,8, 7,7,8,8};
`endif
    in_vec = '{1, 2, 3, 4};
    stream2(5, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", a_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    in_vec = '{5, 6, 7, 8};
    stream2(16, 1'b0);
    checks++;
    if (nout !== 16) begin errors++; $display("FAIL midreset_count: got %0d want 16", nout); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_data[i] !== exp_v[i]) begin errors++; $display("FAIL midreset_data[%0d]: got %0d want %0d", i, cap_data[i], exp_v[i]); end
    end
    checks++;
    if (cap_last !== 16'h8000) begin errors++; $display("FAIL midreset_last: got %h want 8000", cap_last); end
  endtask

  // Expected output beat k of a ramp frame 0..168 upsampled to 26x26
  function automatic px_t exp13(input int k);
    int f, orow, ocol;
    f    = k % 676;
    orow = f / 26;
    ocol = f % 26;
`ifdef UNPOOL_ZERO_FILL_EN
    if ((orow % 2) != 0 || (ocol % 2) != 0) return 0;
`endif
    return px_t'((orow / 2) * 13 + ocol / 2);
  endfunction

  task automatic test_back_to_back();
    int idx, n;
    idx = 0; n = 0;
    for (int k = 0; k < 6000 && n < 1352; k++) begin
      @(negedge clk);
      b_out_ready = 1'b1;
      b_in_valid  = (idx < 338);
      b_in_data   = px_t'(idx % 169);
      #1;
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (b_out_data !== exp13(n)) begin errors++; $display("FAIL frame13_data[%0d]: got %0d want %0d", n, b_out_data, exp13(n)); end
        checks++;
        if (b_out_last !== ((n == 675) || (n == 1351))) begin
          errors++; $display("FAIL frame13_last[%0d]: got %b want %b", n, b_out_last, (n == 675) || (n == 1351));
        end
        n++;
      end
      if (b_in_valid && b_in_ready) idx++;
    end
    b_in_valid = 1'b0;
    checks++;
    if (n !== 1352) begin errors++; $display("FAIL frame13_count: got %0d want 1352", n); end
    checks++;
    if (idx !== 338) begin errors++; $display("FAIL frame13_inputs: got %0d want 338", idx); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_signed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
